pattern_scan_ctrl: RTL and testbench

Frame-level sequencer for the serial `11010` sequence detector FSM. It accepts parallel words over a valid/ready handshake and resets the detector at frame start. It shifts each word into the detector MSB-first, one bit per cycle, and timestamps and counts every detection by bit position within the frame. It sits between a word-wide data source and the single-bit detector instance, which it owns exclusively.

---
 rtl/pattern_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer for a serial 11010 detector: CLR resets the detector, each accepted word shifts out MSB-first, one bit per cycle.
// Latency: a handshake in cycle k produces bits in k+1..k+WORD_W and a match pulse one cycle after its bit; word_ready is high only in LOAD.
module pattern_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              det_reset,
  output logic              det_bit,
  input  logic              det_match,
  output logic              match_valid,
  output logic [CNT_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] shreg;
  logic              last_flag;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  bit_pos;

  logic last_bit;
  logic accept;
  logic hit;

  assign last_bit = (bit_cnt == LAST_BIT);
  assign accept   = (state == S_LOAD) && word_valid;
  assign hit      = (state == S_SHIFT) && det_match;

  // The detector also follows our own reset so it never holds stale history.
  assign det_reset = reset | (state == S_CLR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_LOAD;
      S_LOAD:  if (word_valid) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = last_flag ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    det_bit    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE:  busy       = 1'b0;
      S_LOAD:  word_ready = 1'b1;
      S_SHIFT: det_bit    = shreg[WORD_W-1];
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      last_flag   <= 1'b0;
      bit_cnt     <= '0;
      bit_pos     <= '0;
      match_valid <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
    end else begin
      match_valid <= hit;
      if (hit) begin
        match_pos <= bit_pos;
        if (match_count != '1) begin
          match_count <= match_count + 1'b1;
        end
      end

      if (state == S_CLR) begin
        bit_pos     <= '0;
        match_count <= '0;
      end

      if (accept) begin
        shreg     <= word_data;
        last_flag <= word_last;
        bit_cnt   <= '0;
      end else if (state == S_SHIFT) begin
        shreg   <= {shreg[WORD_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        bit_pos <= bit_pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural 11010 detector plus a scoreboard of expected match positions/counts.
module tb_pattern_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_last;
  logic              word_ready;
  logic              det_reset;
  logic              det_bit;
  logic              det_match;
  logic              match_valid;
  logic [CNT_W-1:0]  match_pos;
  logic [CNT_W-1:0]  match_count;
  logic              busy;
  logic              done;

  pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .det_reset  (det_reset),
    .det_bit    (det_bit),
    .det_match  (det_match),
    .match_valid(match_valid),
    .match_pos  (match_pos),
    .match_count(match_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Detector model: advances only on shift cycles, so stalls between words keep its history.
  logic [3:0] hist;
  logic       in_shift;
  assign in_shift  = busy && !word_ready && !done && !det_reset;
  assign det_match = in_shift && ({hist, det_bit} == 5'b11010);
  always @(posedge clk) begin
    if (det_reset) hist <= 4'b0000;
    else if (in_shift) hist <= {hist[2:0], det_bit};
  end

  typedef struct {
    int pos;
    int cnt;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int mv_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (match_valid) begin
        exp_t e;
        mv_cyc = cyc;
        chk("match_has_expect", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("match_pos", 32'(match_pos), e.pos);
          chk("match_count", 32'(match_count), e.cnt);
        end
      end
    end
  end

  // Sliding-window reference over the frame's bit stream.
  task automatic push_expect(input logic [7:0] w0, input logic [7:0] w1, input int nw,
                             output int tot, output int lastp);
    logic [4:0] win;
    logic [7:0] w;
    int pos;
    win = 5'b0;
    pos = 0;
    tot = 0;
    lastp = 0;
    for (int n = 0; n < nw; n++) begin
      w = (n == 0) ? w0 : w1;
      for (int b = 7; b >= 0; b--) begin
        win = {win[3:0], w[b]};
        if (win == 5'b11010) begin
          tot++;
          lastp = pos;
          sb.push_back('{pos: pos, cnt: tot});
        end
        pos++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag, input logic exp_det_reset);
    chk({tag, "_word_ready"}, 32'(word_ready), 0);
    chk({tag, "_det_bit"}, 32'(det_bit), 0);
    chk({tag, "_match_valid"}, 32'(match_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_match_pos"}, 32'(match_pos), 0);
    chk({tag, "_match_count"}, 32'(match_count), 0);
    chk({tag, "_det_reset"}, 32'(det_reset), 32'(exp_det_reset));
  endtask

  // Entered and left at a negedge where the DUT is in LOAD (or DONE on return for a last word).
  task automatic send_word(input logic [7:0] data, input logic last, input int gap, input bit poke);
    int n;
    word_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_ready", 32'(word_ready), 1);
    end
    word_data  = data;
    word_last  = last;
    word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(word_ready), 1);
    for (int i = 1; i <= WORD_W; i++) begin
      @(negedge clk);
      if (i == 1) begin
        word_valid = 1'b0;
        word_data  = 8'($urandom);
        word_last  = 1'b0;
      end
      chk("shift_ready_low", 32'(word_ready), 0);
      start = poke && (i == 2);
    end
    start = 1'b0;
    @(negedge clk);
    if (last) chk("done_after_word", 32'(done), 1);
    else chk("ready_after_word", 32'(word_ready), 1);
  endtask

  task automatic run_frame(input logic [7:0] w0, input logic [7:0] w1, input int nw,
                           input int gap, input bit poke);
    int tot, lastp, dc;
    push_expect(w0, w1, nw, tot, lastp);
    dc = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_det_reset", 32'(det_reset), 1);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_ready", 32'(word_ready), 0);
    @(negedge clk);
    chk("load_ready", 32'(word_ready), 1);
    send_word(w0, nw == 1, 0, poke);
    if (nw == 2) send_word(w1, 1'b1, gap, 1'b0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("done_once", done_cnt - dc, 1);
    chk("final_count", 32'(match_count), tot);
    chk("sb_drained", sb.size(), 0);
    if (tot > 0) chk("pos_hold", 32'(match_pos), lastp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tot, lastp;
    reset      = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por", 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("por_release_det_reset", 32'(det_reset), 0);
    chk("por_release_busy", 32'(busy), 0);

    // 0xDA: single match on the last bit, coincident with done.
    run_frame(8'hDA, 8'h00, 1, 0, 1'b0);
    chk("da_done_with_match", done_cyc - mv_cyc, 0);

    // 0xD0: match at bit 4; done follows WORD_W-1-4 cycles after the pulse.
    run_frame(8'hD0, 8'h00, 1, 0, 1'b0);
    chk("d0_done_gap", done_cyc - mv_cyc, WORD_W - 1 - 4);

    // Pattern spanning a word boundary, back-to-back and with a 5-cycle stall.
    run_frame(8'h0D, 8'h00, 2, 0, 1'b0);
    run_frame(8'h0D, 8'h00, 2, 5, 1'b0);

    // Two matches in one frame.
    run_frame(8'hDA, 8'hD0, 2, 0, 1'b0);

    // Reset during the 3rd shift cycle of an 0xD0 frame.
    push_expect(8'hD0, 8'h00, 1, tot, lastp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_load_ready", 32'(word_ready), 1);
    word_data  = 8'hD0;
    word_last  = 1'b1;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst", 1'b1);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", 32'(busy), 0);
    chk("midrst_no_done", 32'(done), 0);
    run_frame(8'hD0, 8'h00, 1, 0, 1'b0);

    // Back-to-back frames with a stray start mid-frame.
    run_frame(8'hDA, 8'h00, 1, 0, 1'b1);
    run_frame(8'hD0, 8'h00, 1, 0, 1'b0);
    chk("b2b_match_pos", 32'(match_pos), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
